calc_div_seq: RTL and testbench



---
 rtl/calc_pkg.sv | 16 +
 rtl/calc_div_step.sv | 36 +++
 rtl/calc_div_seq.sv | 113 +++++++++++
 tb/tb_calc_div_seq.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/calc_pkg.sv
// Shared types and constants for the calculator's sequential divide path.
package calc_pkg;

  // Default operand width of the divide datapath.
  localparam int CALC_W = 4;

  // Quotient reported for a divide by zero (all ones).
  localparam logic [CALC_W-1:0] DIV_ZERO_Q = '1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } calc_state_e;

endpackage

// File: rtl/calc_div_step.sv
// One combinational restoring-division step: shift {prem,qsr} left by one,
// trial-subtract the divisor, and keep the difference if it did not go negative.
module calc_div_step
  import calc_pkg::*;
#(
  parameter int WIDTH = CALC_W
) (
  input  logic [WIDTH:0]   prem,
  input  logic [WIDTH-1:0] qsr,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH:0]   prem_next,
  output logic [WIDTH-1:0] qsr_next
);

  logic [WIDTH:0] prem_shift;
  logic [WIDTH:0] trial;
  // The partial remainder entering a step is always below 2**WIDTH, so its
  // MSB carries no information and is dropped by the shift.
  logic           prem_msb_unused;

  assign prem_msb_unused = prem[WIDTH];
  assign prem_shift      = {prem[WIDTH-1:0], qsr[WIDTH-1]};
  assign trial           = prem_shift - {1'b0, b};

  // Restore on a negative trial (MSB set), otherwise accept it and emit a 1.
  always_comb begin
    if (trial[WIDTH] == 1'b0) begin
      prem_next = trial;
      qsr_next  = {qsr[WIDTH-2:0], 1'b1};
    end else begin
      prem_next = prem_shift;
      qsr_next  = {qsr[WIDTH-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/calc_div_seq.sv
// Sequential unsigned divider: start/ready handshake, one quotient bit per
// cycle, registered q/rem/div_zero with a one-cycle done pulse.
// Optional build macro CALC_DIV_ZERO_TRAP_EN: a divide by zero skips the
// WIDTH-step run and completes one cycle after acceptance.
module calc_div_seq
  import calc_pkg::*;
#(
  parameter int WIDTH = CALC_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] rem,
  output logic             div_zero
);

  localparam int CNT_W = $clog2(WIDTH + 1);

`ifdef CALC_DIV_ZERO_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  calc_state_e      state;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] qsr;
  logic [WIDTH:0]   prem;
  logic [WIDTH-1:0] b_reg;
  logic [WIDTH:0]   prem_next;
  logic [WIDTH-1:0] qsr_next;

  calc_div_step #(.WIDTH(WIDTH)) u_step (
    .prem      (prem),
    .qsr       (qsr),
    .b         (b_reg),
    .prem_next (prem_next),
    .qsr_next  (qsr_next)
  );

  // Control FSM and datapath registers; every output is registered.
  // NOTE: sequential state uses non-blocking (<=) so all registers update
  // together from pre-edge values; blocking here would create ordering races.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      qsr      <= '0;
      prem     <= '0;
      b_reg    <= '0;
      ready    <= 1'b1;
      busy     <= 1'b0;
      done     <= 1'b0;
      q        <= '0;
      rem      <= '0;
      div_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            qsr   <= a;
            b_reg <= b;
            prem  <= '0;
            cnt   <= CNT_W'(WIDTH);
            ready <= 1'b0;
            busy  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          if (TRAP_EN && b_reg == '0) begin
            // Divide-by-zero shortcut: same results the full run would give.
            q        <= {WIDTH{DIV_ZERO_Q[0]}};
            rem      <= qsr;
            div_zero <= 1'b1;
            done     <= 1'b1;
            busy     <= 1'b0;
            state    <= DONE;
          end else begin
            qsr  <= qsr_next;
            prem <= prem_next;
            cnt  <= cnt - CNT_W'(1);
            if (cnt == CNT_W'(1)) begin
              q        <= qsr_next;
              rem      <= prem_next[WIDTH-1:0];
              div_zero <= (b_reg == '0);
              done     <= 1'b1;
              busy     <= 1'b0;
              state    <= DONE;
            end
          end
        end
        DONE: begin
          ready <= 1'b1;
          state <= IDLE;
        end
        default: begin
          ready <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_calc_div_seq.sv
// Self-checking bench for calc_div_seq (WIDTH=4): directed vector table,
// exhaustive back-to-back sweep, and hand-written handshake/reset sequences.
module tb_calc_div_seq;

  localparam int W = 4;

`ifdef CALC_DIV_ZERO_TRAP_EN
  localparam int ZERO_LAT = 1;
`else
  localparam int ZERO_LAT = W;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         ready;
  logic         busy;
  logic         done;
  logic [W-1:0] q;
  logic [W-1:0] rem;
  logic         div_zero;

  int checks = 0;
  int errors = 0;

  calc_div_seq #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .a        (a),
    .b        (b),
    .ready    (ready),
    .busy     (busy),
    .done     (done),
    .q        (q),
    .rem      (rem),
    .div_zero (div_zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] q;
    logic [W-1:0] rem;
    logic         dz;
  } vec_t;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d expected=%0d", name, got, exp);
    end
  endtask

  // Runs one divide from the current point (#1 after a posedge) and checks
  // latency, results, ready behaviour and the done pulse width.
  task automatic do_op(input logic [W-1:0] av, input logic [W-1:0] bv,
                       input logic [W-1:0] eq, input logic [W-1:0] er,
                       input logic ez, input int exp_lat, input string name);
    int n;
    int lat;
    logic ready_seen;
    n = 0;
    while (!ready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check({name, "_ready_wait"}, ready, 1'b1);
    a = av;
    b = bv;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    a = W'($urandom);
    b = W'($urandom);
    lat = 0;
    ready_seen = 1'b0;
    while (!done && lat < 20) begin
      if (ready) ready_seen = 1'b1;
      @(posedge clk); #1;
      lat++;
    end
    check({name, "_latency"}, lat, exp_lat);
    check({name, "_q"}, q, eq);
    check({name, "_rem"}, rem, er);
    check({name, "_div_zero"}, div_zero, ez);
    check({name, "_ready_low"}, ready_seen | ready, 1'b0);
    @(posedge clk); #1;
    check({name, "_done_width"}, done, 1'b0);
    check({name, "_ready_back"}, ready, 1'b1);
  endtask

  vec_t vecs[9];

  initial begin
    int ndone;
    logic [W-1:0] cq;
    logic [W-1:0] cr;

    vecs[0] = '{a: 4'd13, b: 4'd4,  q: 4'd3,  rem: 4'd1, dz: 1'b0};
    vecs[1] = '{a: 4'd9,  b: 4'd0,  q: 4'd15, rem: 4'd9, dz: 1'b1};
    vecs[2] = '{a: 4'd7,  b: 4'd9,  q: 4'd0,  rem: 4'd7, dz: 1'b0};
    vecs[3] = '{a: 4'd15, b: 4'd1,  q: 4'd15, rem: 4'd0, dz: 1'b0};
    vecs[4] = '{a: 4'd12, b: 4'd5,  q: 4'd2,  rem: 4'd2, dz: 1'b0};
    vecs[5] = '{a: 4'd0,  b: 4'd7,  q: 4'd0,  rem: 4'd0, dz: 1'b0};
    vecs[6] = '{a: 4'd15, b: 4'd15, q: 4'd1,  rem: 4'd0, dz: 1'b0};
    vecs[7] = '{a: 4'd14, b: 4'd3,  q: 4'd4,  rem: 4'd2, dz: 1'b0};
    vecs[8] = '{a: 4'd0,  b: 4'd0,  q: 4'd15, rem: 4'd0, dz: 1'b1};

    rst = 1'b1;
    start = 1'b0;
    a = '0;
    b = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready", ready, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_q", q, 0);
    check("rst_rem", rem, 0);
    check("rst_div_zero", div_zero, 1'b0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Directed table (includes 9/0 then 7/9 and 15/1 clearing div_zero).
    foreach (vecs[i]) begin
      do_op(vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].rem, vecs[i].dz,
            (vecs[i].b == '0) ? ZERO_LAT : W, $sformatf("vec%0d", i));
    end

    // Exhaustive sweep of nonzero divisors, back-to-back at earliest ready.
    for (int ai = 0; ai < 16; ai++) begin
      for (int bi = 1; bi < 16; bi++) begin
        do_op(W'(ai), W'(bi), W'(ai / bi), W'(ai % bi), 1'b0, W,
              $sformatf("sweep_%0d_%0d", ai, bi));
      end
    end

    // start re-pulsed during RUN must be ignored.
    a = 4'd12;
    b = 4'd5;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    check("ignore_busy", busy, 1'b1);
    a = 4'd2;
    b = 4'd1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    ndone = 0;
    cq = '0;
    cr = '0;
    for (int c = 0; c < 12; c++) begin
      if (done) begin
        ndone++;
        cq = q;
        cr = rem;
      end
      @(posedge clk); #1;
    end
    check("ignore_done_count", ndone, 1);
    check("ignore_q", cq, 4'd2);
    check("ignore_rem", cr, 4'd2);
    check("ignore_idle", ready, 1'b1);

    // Asynchronous reset in the second RUN cycle aborts the op.
    a = 4'd13;
    b = 4'd4;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    check("abort_ready", ready, 1'b1);
    check("abort_busy", busy, 1'b0);
    check("abort_done", done, 1'b0);
    check("abort_q", q, 0);
    check("abort_rem", rem, 0);
    check("abort_div_zero", div_zero, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    ndone = 0;
    for (int c = 0; c < 8; c++) begin
      if (done) ndone++;
      @(posedge clk); #1;
    end
    check("abort_no_done", ndone, 0);
    do_op(4'd6, 4'd3, 4'd2, 4'd0, 1'b0, W, "after_abort");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
